// File: rtl/vga_pkg.sv
// Shared VGA definitions: screen size, default bitmap size, colour and timing types.
package vga_pkg;

  localparam int HOR_PIXELS      = 800;
  localparam int VER_PIXELS      = 600;
  localparam int RECT_WIDTH_DEF  = 64;
  localparam int RECT_HEIGHT_DEF = 64;

  typedef logic [11:0] rgb_t;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
  } vga_timing_t;

  localparam int TIMING_W = $bits(vga_timing_t);

  // True while either blanking strobe is active; such pixels must be black.
  function automatic logic blank_f(input vga_timing_t t);
    return t.hblnk | t.vblnk;
  endfunction

endpackage

// File: rtl/draw_rect_img_delay_line.sv
// Fixed-length register pipeline with synchronous active-low clear.
module delay_line #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [CLK_DEL];

  // Shift the word one stage per clock; reset clears every stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < CLK_DEL; i++) begin
        pipe_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      pipe_q[0] <= din;
      for (int i = 1; i < CLK_DEL; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign dout = pipe_q[CLK_DEL-1];

endmodule

// File: rtl/draw_rect_img.sv
// Rectangle bitmap overlay: latches the position once per frame, addresses an
// external 1-cycle image ROM and composites its data onto the background with
// the timing stream delayed by two cycles.
module draw_rect_img
  import vga_pkg::*;
#(
  parameter int RECT_WIDTH  = RECT_WIDTH_DEF,
  parameter int RECT_HEIGHT = RECT_HEIGHT_DEF,
  parameter int ADDR_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [10:0]           hcount_in,
  input  logic [10:0]           vcount_in,
  input  logic                  hsync_in,
  input  logic                  hblnk_in,
  input  logic                  vsync_in,
  input  logic                  vblnk_in,
  input  logic [11:0]           rgb_in,
  input  logic [11:0]           xpos,
  input  logic [11:0]           ypos,
  input  logic [11:0]           rgb_pixel,
  output logic [ADDR_WIDTH-1:0] pixel_addr,
  output logic [10:0]           hcount_out,
  output logic [10:0]           vcount_out,
  output logic                  hsync_out,
  output logic                  hblnk_out,
  output logic                  vsync_out,
  output logic                  vblnk_out,
  output logic [11:0]           rgb_out
);

  localparam int XW    = $clog2(RECT_WIDTH);
  localparam int YW    = $clog2(RECT_HEIGHT);
  localparam int S1_W  = TIMING_W + 1 + 12;
  localparam int S2_W  = TIMING_W + 2 + 12;

  logic                  vblnk_prev_q;
  logic [11:0]           x_lat_q, x_lat_d;
  logic [11:0]           y_lat_q, y_lat_d;
  logic [ADDR_WIDTH-1:0] pixel_addr_q, pixel_addr_d;
  logic                  in_rect_s;
  logic [XW-1:0]         dx_s;
  logic [YW-1:0]         dy_s;
  logic [12:0]           h13_s, v13_s, xl13_s, yl13_s;

  vga_timing_t           tim_in_s, tim_s1_s, tim_s2_s;
  logic                  in_rect_s1_s, in_rect_s2_s, blank_s2_s;
  rgb_t                  rgb_s1_s, rgb_s2_s;
  logic [S1_W-1:0]       s1_bus_s;
  logic [S2_W-1:0]       s2_bus_s;

  // Capture a new position only on the rising edge of vblnk so a frame never tears.
  always_comb begin
    x_lat_d = x_lat_q;
    y_lat_d = y_lat_q;
    if (vblnk_in && !vblnk_prev_q) begin
      x_lat_d = xpos;
      y_lat_d = ypos;
    end else begin
      x_lat_d = x_lat_q;
      y_lat_d = y_lat_q;
    end
  end

  // Hit test at 13 bits so x_lat+RECT_WIDTH cannot wrap; address from low offset bits.
  always_comb begin
    h13_s  = {2'b00, hcount_in};
    v13_s  = {2'b00, vcount_in};
    xl13_s = {1'b0, x_lat_q};
    yl13_s = {1'b0, y_lat_q};
    in_rect_s = (h13_s >= xl13_s) && (h13_s < xl13_s + 13'(RECT_WIDTH)) &&
                (v13_s >= yl13_s) && (v13_s < yl13_s + 13'(RECT_HEIGHT));
    // Low bits of a difference depend only on low bits of the operands.
    dx_s = hcount_in[XW-1:0] - x_lat_q[XW-1:0];
    dy_s = vcount_in[YW-1:0] - y_lat_q[YW-1:0];
    if (in_rect_s) begin
      pixel_addr_d = ADDR_WIDTH'({dy_s, dx_s});
    end else begin
      pixel_addr_d = {ADDR_WIDTH{1'b0}};
    end
  end

  // Position latch, vblnk edge history and the ROM address register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vblnk_prev_q <= 1'b0;
      x_lat_q      <= 12'd0;
      y_lat_q      <= 12'd0;
      pixel_addr_q <= {ADDR_WIDTH{1'b0}};
    end else begin
      vblnk_prev_q <= vblnk_in;
      x_lat_q      <= x_lat_d;
      y_lat_q      <= y_lat_d;
      pixel_addr_q <= pixel_addr_d;
    end
  end

  // Pack the incoming timing strobes into the shared bundle.
  always_comb begin
    tim_in_s.hcount = hcount_in;
    tim_in_s.vcount = vcount_in;
    tim_in_s.hsync  = hsync_in;
    tim_in_s.hblnk  = hblnk_in;
    tim_in_s.vsync  = vsync_in;
    tim_in_s.vblnk  = vblnk_in;
  end

  delay_line #(.WIDTH(S1_W), .CLK_DEL(1)) u_stage1 (
    .clk  (clk),
    .rst  (rst),
    .din  ({tim_in_s, in_rect_s, rgb_in}),
    .dout (s1_bus_s)
  );

  assign {tim_s1_s, in_rect_s1_s, rgb_s1_s} = s1_bus_s;

  delay_line #(.WIDTH(S2_W), .CLK_DEL(1)) u_stage2 (
    .clk  (clk),
    .rst  (rst),
    .din  ({tim_s1_s, blank_f(tim_s1_s), in_rect_s1_s, rgb_s1_s}),
    .dout (s2_bus_s)
  );

  assign {tim_s2_s, blank_s2_s, in_rect_s2_s, rgb_s2_s} = s2_bus_s;

  // Final mux: every select is a stage-2 register and rgb_pixel is the ROM's own
  // output register, so ROM data for a pixel meets its timing on the same cycle.
  always_comb begin
    rgb_out = 12'h000;
    if (blank_s2_s) begin
      rgb_out = 12'h000;
    end else if (in_rect_s2_s) begin
      rgb_out = rgb_pixel;
    end else begin
      rgb_out = rgb_s2_s;
    end
  end

  assign pixel_addr = pixel_addr_q;
  assign hcount_out = tim_s2_s.hcount;
  assign vcount_out = tim_s2_s.vcount;
  assign hsync_out  = tim_s2_s.hsync;
  assign hblnk_out  = tim_s2_s.hblnk;
  assign vsync_out  = tim_s2_s.vsync;
  assign vblnk_out  = tim_s2_s.vblnk;

endmodule

// File: tb/tb_draw_rect_img.sv
// Directed bench for draw_rect_img with a 1-cycle ROM model (ROM[a] = a ^ 12'hA5C).
module tb_draw_rect_img;

  logic        clk;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_in, xpos, ypos, rgb_pixel;
  logic [11:0] pixel_addr;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;

  int n_checks = 0;
  int n_errors = 0;

  draw_rect_img #(.RECT_WIDTH(64), .RECT_HEIGHT(64), .ADDR_WIDTH(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .hblnk_in   (hblnk_in),
    .vsync_in   (vsync_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .xpos       (xpos),
    .ypos       (ypos),
    .rgb_pixel  (rgb_pixel),
    .pixel_addr (pixel_addr),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .hblnk_out  (hblnk_out),
    .vsync_out  (vsync_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous image ROM model with one cycle of read latency.
  always_ff @(posedge clk) begin
    rgb_pixel <= pixel_addr ^ 12'hA5C;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic hb,
                       input logic vb, input logic [11:0] rgb);
    hcount_in = h;
    vcount_in = v;
    hsync_in  = h[0];
    vsync_in  = v[0];
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = rgb;
  endtask

  // Hold one pixel for two cycles; address checked at +1, composited pixel at +2.
  task automatic pixel(input string tag, input logic [10:0] h, input logic [10:0] v,
                       input logic hb, input logic vb, input logic [11:0] rgb,
                       input logic [11:0] exp_addr, input logic [11:0] exp_rgb);
    drive(h, v, hb, vb, rgb);
    tick();
    check_val({tag, "_addr"}, pixel_addr, exp_addr);
    tick();
    check_val({tag, "_rgb"}, rgb_out, exp_rgb);
    check_val({tag, "_hcnt"}, hcount_out, h);
    check_val({tag, "_vcnt"}, vcount_out, v);
    check_val({tag, "_sync"}, {hsync_out, vsync_out}, {h[0], v[0]});
    check_val({tag, "_blnk"}, {hblnk_out, vblnk_out}, {hb, vb});
  endtask

  // Produce a rising edge of vblnk_in so the current xpos/ypos get latched.
  task automatic frame_start();
    drive(11'd0, 11'd0, 1'b1, 1'b0, 12'h000);
    tick();
    drive(11'd0, 11'd0, 1'b1, 1'b1, 12'h000);
    tick();
    tick();
  endtask

  initial begin
    logic [11:0] a;
    rst  = 1'b0;
    xpos = 12'd0;
    ypos = 12'd0;
    drive(11'd5, 11'd7, 1'b0, 1'b0, 12'hABC);

    // Reset: everything zero while rst is low.
    tick(); tick(); tick();
    check_val("rst_hcnt", hcount_out, 32'd0);
    check_val("rst_vcnt", vcount_out, 32'd0);
    check_val("rst_rgb",  rgb_out,    32'd0);
    check_val("rst_addr", pixel_addr, 32'd0);
    check_val("rst_sync", {hsync_out, vsync_out}, 32'd0);

    // After release the rectangle sits at (0,0).
    rst = 1'b1;
    pixel("rel", 11'd10, 11'd20, 1'b0, 1'b0, 12'h111, 12'h50A, 12'hF56);

    // Frame capture at (100,50).
    xpos = 12'd100;
    ypos = 12'd50;
    frame_start();
    pixel("cap_org",   11'd100, 11'd50,  1'b0, 1'b0, 12'h123, 12'h000, 12'hA5C);
    pixel("cap_end",   11'd163, 11'd113, 1'b0, 1'b0, 12'h123, 12'hFFF, 12'h5A3);
    pixel("cap_right", 11'd164, 11'd50,  1'b0, 1'b0, 12'h456, 12'h000, 12'h456);
    pixel("cap_left",  11'd99,  11'd50,  1'b0, 1'b0, 12'h789, 12'h000, 12'h789);
    pixel("cap_below", 11'd100, 11'd114, 1'b0, 1'b0, 12'h321, 12'h000, 12'h321);

    // Streaming: address lags inputs by one cycle, colour/timing by two.
    for (int i = 0; i < 8; i++) begin
      drive(11'(100 + i), 11'd60, 1'b0, 1'b0, 12'h000);
      tick();
      check_val("strm_addr", pixel_addr, 32'(640 + i));
      if (i >= 1) begin
        a = 12'(640 + i - 1);
        check_val("strm_rgb",  rgb_out,    a ^ 12'hA5C);
        check_val("strm_hcnt", hcount_out, 32'(100 + i - 1));
      end
    end

    // Mid-frame move is ignored until the next vblnk rise.
    xpos = 12'd300;
    pixel("mid_old", 11'd100, 11'd60, 1'b0, 1'b0, 12'h0F0, 12'h280, 12'h8DC);
    pixel("mid_new", 11'd300, 11'd60, 1'b0, 1'b0, 12'h0F0, 12'h000, 12'h0F0);
    frame_start();
    pixel("nf_new",  11'd300, 11'd60, 1'b0, 1'b0, 12'h00F, 12'h280, 12'h8DC);
    pixel("nf_old",  11'd100, 11'd60, 1'b0, 1'b0, 12'h00F, 12'h000, 12'h00F);

    // Edge clip at (780,590): blanked pixels are black.
    xpos = 12'd780;
    ypos = 12'd590;
    frame_start();
    pixel("clip_org",    11'd780, 11'd590, 1'b0, 1'b0, 12'hFFF, 12'h000, 12'hA5C);
    pixel("clip_corner", 11'd799, 11'd599, 1'b0, 1'b0, 12'hFFF, 12'h253, 12'h80F);
    pixel("clip_h",      11'd800, 11'd590, 1'b1, 1'b0, 12'hFFF, 12'h014, 12'h000);
    pixel("clip_v",      11'd780, 11'd600, 1'b0, 1'b1, 12'hFFF, 12'h280, 12'h000);

    // Off-screen rectangle never hits.
    xpos = 12'd4090;
    ypos = 12'd0;
    frame_start();
    pixel("off_a", 11'd0,    11'd0,  1'b0, 1'b0, 12'hC3C, 12'h000, 12'hC3C);
    pixel("off_b", 11'd2047, 11'd63, 1'b0, 1'b0, 12'h3C3, 12'h000, 12'h3C3);

    // Mid-frame reset: outputs zero, then rectangle at (0,0) until the next rise.
    xpos = 12'd200;
    ypos = 12'd100;
    drive(11'd300, 11'd300, 1'b0, 1'b0, 12'h777);
    rst = 1'b0;
    tick(); tick();
    check_val("mrst_rgb",  rgb_out,    32'd0);
    check_val("mrst_hcnt", hcount_out, 32'd0);
    check_val("mrst_addr", pixel_addr, 32'd0);
    rst = 1'b1;
    pixel("mrst_zero", 11'd10,  11'd20,  1'b0, 1'b0, 12'h777, 12'h50A, 12'hF56);
    pixel("mrst_wait", 11'd200, 11'd100, 1'b0, 1'b0, 12'h777, 12'h000, 12'h777);
    frame_start();
    pixel("mrst_new",  11'd200, 11'd100, 1'b0, 1'b0, 12'h777, 12'h000, 12'hA5C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/draw_rect_img.md
# draw_rect_img

Rectangle image overlay stage that sits directly downstream of the rectangle position controller. It takes the VGA timing stream and background colour, plus the controller's `xpos`/`ypos`. It then overlays a RECT_WIDTH×RECT_HEIGHT bitmap fetched from an external synchronous image ROM. Timing signals are delayed to match the ROM read, so the VGA output stage sees an aligned stream.

## Interface
Parameters:
- RECT_WIDTH, 64, bitmap width in pixels (power of two)
- RECT_HEIGHT, 64, bitmap height in pixels (power of two)
- ADDR_WIDTH, 12, ROM address width = log2(RECT_WIDTH)+log2(RECT_HEIGHT)

Ports:
- clk  in  1  pixel clock; single clock domain
- rst  in  1  reset, synchronous, active-low (rst=0 resets on the rising clk edge)
- hcount_in / vcount_in  in  11 each  pixel counters
- hsync_in, hblnk_in, vsync_in, vblnk_in  in  1 each  timing strobes
- rgb_in  in  12  background colour {R4,G4,B4}
- xpos, ypos  in  12 each  rectangle top-left corner from the position controller
- rgb_pixel  in  12  ROM data, valid one cycle after `pixel_addr`
- pixel_addr  out  ADDR_WIDTH  ROM address = {row[log2 H-1:0], col[log2 W-1:0]}
- hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out  out  timing delayed by 2 cycles
- rgb_out  out  12  composited colour, aligned with the *_out timing signals

## Operation
- **Frame-coherent position:** `xpos`/`ypos` are captured into `x_lat`/`y_lat` only on the cycle where `vblnk_in`=1 and the registered previous `vblnk_in`=0 (rising edge). Otherwise they are held.
  - Rationale: the controller may move the rectangle mid-frame, and this capture prevents tearing.
- **Stage 1 (register at cycle +1):**
  - All `*_in` signals are registered.
  - `in_rect` = (hcount_in ≥ x_lat) && (hcount_in < x_lat+RECT_WIDTH) && (vcount_in ≥ y_lat) && (vcount_in < y_lat+RECT_HEIGHT).
  - All compares are evaluated at 13 bits, so `x_lat`+RECT_WIDTH never wraps.
  - `pixel_addr` = {(vcount_in−y_lat) low bits, (hcount_in−x_lat) low bits} when `in_rect`, else 0.
- **Stage 2 (register at cycle +2):** timing signals are registered again. Then:
  - `rgb_out` = 12'h000 if the stage-1 `hblnk` or `vblnk` is set;
  - else `rgb_pixel` if the stage-1 `in_rect` is set;
  - else the stage-1 `rgb_in`.
- A rectangle that extends partly past the visible area is clipped naturally: pixels falling in blanking are forced black.
- `xpos`/`ypos` up to 4095 are legal. If the rectangle lies entirely off-screen, nothing is drawn.
- No transparency; every ROM value, including 12'h000, is drawn.

## Timing
- Latency from any `*_in` signal to the corresponding `*_out`/`rgb_out`: exactly 2 clk cycles.
- `pixel_addr` is registered and valid 1 cycle after its inputs. The ROM must have exactly 1-cycle read latency.
- Position update takes effect from the first active pixel after the `vblnk_in` rise. Pixels already in the pipeline keep the old position.
- **Reset (rst=0):**
  - Values forced on the next edge:
    - all outputs = 0;
    - `x_lat` = `y_lat` = 0;
    - stage registers = 0;
    - the previous-`vblnk` register = 0.
  - Mid-frame reset: outputs are 0 during reset.
  - After release, the first 2 cycles carry pipeline-flushed zeros.
  - The rectangle is drawn at (0,0) until the next `vblnk_in` rise.
- **`vblnk_in` already 1 when reset releases:**
  - the previous-`vblnk` register is 0, so a capture occurs on the first cycle after release;
  - this is accepted behaviour.

## Structure
- A shared package `vga_pkg` holds:
  - screen constants: HOR_PIXELS=800, VER_PIXELS=600;
  - RECT_WIDTH/RECT_HEIGHT defaults;
  - the `rgb_t` typedef (12-bit);
  - the `vga_timing_t` struct (hcount, vcount, hsync, hblnk, vsync, vblnk), used for stage registers.
- One natural sub-module: `delay_line`, parameterised by WIDTH and CLK_DEL.
  - It carries the packed timing bundle through the stages.
  - `in_rect` and `rgb_in` ride alongside at stage 1.
- The image ROM (`image_rom`) is external and instantiated by the parent.

## Test plan
- Reset → with rst=0 for 3 cycles, all outputs and `pixel_addr` are 0; 2 cycles after release, `hcount_out` tracks `hcount_in`.
- Frame capture → xpos=100, ypos=50 applied before a `vblnk_in` rise. Next frame, pixel (100,50): `pixel_addr`=0 at +1 cycle, `rgb_out`=ROM[0] at +2 cycles. Pixel (163,113): addr 12'hFFF. Pixel (164,50): `rgb_out`=`rgb_in`.
- Mid-frame move → xpos changes 100→300 at vcount=200. Rows 200–599 still draw at x=100; the next frame draws at x=300.
- Edge clip → xpos=780, ypos=590. Pixels with hcount ≥ 800 or vcount ≥ 600 have `rgb_out`=0 (blanking); the visible corner (780..799, 590..599) shows ROM data.
- Off-screen → xpos=4090: no `in_rect` ever, and `rgb_out`=`rgb_in` delayed by 2 cycles across the whole frame.
- Reset mid-frame → rst=0 at vcount=300. Outputs are 0; after release, the rectangle is at (0,0) until the next `vblnk_in` rise, then at the current xpos/ypos.
